mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 120 ++++++++++++
 tb/tb_mem_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed scratch RAM behind the request-unit bus: byte-select writes, registered reads,
// fixed programmable wait per access and a one-cycle error pulse on the completion cycle.
module mem_responder #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] adr_to_mem,
    input  logic [31:0] data_to_mem,
    input  logic [3:0]  sel_to_mem,
    output logic        mem_busy,
    output logic [31:0] data_from_mem,
    output logic        mem_err
);

    localparam int unsigned Depth   = 2 ** ADDR_BITS;
    localparam logic [3:0]  LoadCnt = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e                 state_q;
    logic [3:0]             cnt_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [31:0]            wdata_q;
    logic [3:0]             sel_q;
    logic                   we_q;
    logic                   oor_q;
    logic                   err_q;
    logic [31:0]            rdata_q;
    logic                   mem_err_q;

    logic [31:0]            mem_q [Depth];

    logic                   req;
    logic                   req_oor;
    logic                   fire;
    logic                   mem_we;
    logic                   unused_adr_bits;

    assign req     = mem_read | mem_write;
    assign req_oor = |adr_to_mem[31:ADDR_BITS+2];
    // The access executes on the last WAIT edge; the counter has reached zero there.
    assign fire    = (state_q == StWait) && (cnt_q == 4'd0);
    assign mem_we  = fire && we_q && !oor_q && !rst;

    // Byte offset bits carry no meaning for a word-wide memory.
    assign unused_adr_bits = ^adr_to_mem[1:0];

    assign mem_busy      = ((state_q == StIdle) && req) || (state_q == StWait);
    assign data_from_mem = rdata_q;
    assign mem_err       = mem_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            wdata_q   <= 32'h0;
            sel_q     <= 4'h0;
            we_q      <= 1'b0;
            oor_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
            mem_err_q <= 1'b0;
        end else begin
            mem_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        idx_q   <= adr_to_mem[ADDR_BITS+1:2];
                        wdata_q <= data_to_mem;
                        sel_q   <= sel_to_mem;
                        // Simultaneous read and write resolves to a write, flagged as an error.
                        we_q    <= mem_write;
                        oor_q   <= req_oor;
                        err_q   <= req_oor | (mem_read & mem_write);
                        cnt_q   <= LoadCnt;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        if (!we_q) begin
                            rdata_q <= oor_q ? 32'h0 : mem_q[idx_q];
                        end
                        mem_err_q <= err_q;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Array has no reset; only enabled lanes of an in-range write are touched.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, reset and early-drop sequences, and a random
// scoreboard sweep over LATENCY = 1, 2 and 15.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [1:0]  cur;

    logic [2:0]  rd_v;
    logic [2:0]  wr_v;
    logic [2:0]  busy_v;
    logic [2:0]  err_v;
    logic [31:0] dout_v [3];
    logic        busy;
    logic        merr;
    logic [31:0] dout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_req
        assign rd_v[k] = mem_read  & (cur == 2'(k));
        assign wr_v[k] = mem_write & (cur == 2'(k));
    end

    assign busy = busy_v[cur];
    assign merr = err_v[cur];
    assign dout = dout_v[cur];

    mem_responder #(.ADDR_BITS(10), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .mem_read(rd_v[0]), .mem_write(wr_v[0]), .adr_to_mem(adr),
        .data_to_mem(wdat), .sel_to_mem(sel), .mem_busy(busy_v[0]), .data_from_mem(dout_v[0]),
        .mem_err(err_v[0])
    );
    mem_responder #(.ADDR_BITS(10), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .mem_read(rd_v[1]), .mem_write(wr_v[1]), .adr_to_mem(adr),
        .data_to_mem(wdat), .sel_to_mem(sel), .mem_busy(busy_v[1]), .data_from_mem(dout_v[1]),
        .mem_err(err_v[1])
    );
    mem_responder #(.ADDR_BITS(10), .LATENCY(15)) u_dut_l15 (
        .clk(clk), .rst(rst), .mem_read(rd_v[2]), .mem_write(wr_v[2]), .adr_to_mem(adr),
        .data_to_mem(wdat), .sel_to_mem(sel), .mem_busy(busy_v[2]), .data_from_mem(dout_v[2]),
        .mem_err(err_v[2])
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vt[$];

    // Reference model: plain word store plus the last value a read returned.
    logic [31:0] model_mem [int];
    logic [31:0] model_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] ed, input logic ee);
        vt.push_back('{rd, wr, a, d, s, ed, ee});
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic model_op(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] exp_d, output logic exp_e);
        logic oor = (a[31:12] != 20'h0);
        int   w   = int'(a[11:2]);
        if (wr) begin
            if (!oor) model_mem[w] = merge(model_mem.exists(w) ? model_mem[w] : 32'h0, d, s);
        end else begin
            model_last = oor ? 32'h0 : model_mem[w];
        end
        exp_e = oor || (rd && wr);
        exp_d = model_last;
    endtask

    // Entered and left at posedge+1; the request stays high through the DONE exit edge.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rdata, output logic err,
                        output int blen);
        bit ok = 1'b0;
        mem_read  = rd;
        mem_write = wr;
        adr       = a;
        wdat      = d;
        sel       = s;
        blen      = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            blen++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL timeout: busy high for %0d cycles, required to drop", blen);
        end
        rdata = dout;
        err   = merr;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        model_last = 32'h0;
    endtask

    logic [31:0] rdata;
    logic [31:0] ed;
    logic        rerr;
    logic        ee;
    int          blen;

    initial begin
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        adr       = 32'h0;
        wdat      = 32'h0;
        sel       = 4'h0;
        cur       = 2'd1;
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", {31'h0, busy}, 32'h0);
            check("idle_err", {31'h0, merr}, 32'h0);
            check("idle_data", dout, 32'h0);
        end
        @(posedge clk);
        #1;

        add(0, 1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        0);
        add(1, 0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 0);
        add(0, 1, 32'h10,       32'h11223344, 4'hF, 32'hDEADBEEF, 0);
        add(0, 1, 32'h10,       32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 0);
        add(1, 0, 32'h10,       32'h0,        4'h0, 32'h11BB33DD, 0);
        add(0, 1, 32'h10,       32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 0);
        add(1, 0, 32'h13,       32'h0,        4'h1, 32'h11BB33DD, 0);
        add(0, 1, 32'h0,        32'hCAFEF00D, 4'hF, 32'h11BB33DD, 0);
        add(1, 0, 32'h1000,     32'h0,        4'hF, 32'h0,        1);
        add(0, 1, 32'h1000,     32'h55555555, 4'hF, 32'h0,        1);
        add(1, 0, 32'h0,        32'h0,        4'hF, 32'hCAFEF00D, 0);
        add(1, 1, 32'h14,       32'h0BADC0DE, 4'hF, 32'hCAFEF00D, 1);
        add(1, 0, 32'h14,       32'h0,        4'hF, 32'h0BADC0DE, 0);
        add(0, 1, 32'h20,       32'h0F0F0F0F, 4'hF, 32'h0BADC0DE, 0);
        add(1, 0, 32'h80000020, 32'h0,        4'hF, 32'h0,        1);
        add(0, 1, 32'h10,       32'h5A5A5A5A, 4'hA, 32'h0,        0);
        add(1, 0, 32'h10,       32'h0,        4'h0, 32'h5ABB5ADD, 0);

        foreach (vt[i]) begin
            xfer(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, vt[i].s, rdata, rerr, blen);
            check($sformatf("vec%0d_data", i), rdata, vt[i].exp_d);
            check($sformatf("vec%0d_err", i), {31'h0, rerr}, {31'h0, vt[i].exp_e});
            check($sformatf("vec%0d_busy_len", i), blen, 32'd3);
        end

        // Reset in cycle 1 of a write drops it.
        mem_write = 1'b1;
        adr       = 32'h20;
        wdat      = 32'h12345678;
        sel       = 4'hF;
        @(negedge clk);
        check("rstwait_busy_c0", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        mem_write = 1'b0;
        @(negedge clk);
        check("rstwait_busy_c1", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstwait_busy_after", {31'h0, busy}, 32'h0);
            check("rstwait_err_after", {31'h0, merr}, 32'h0);
            check("rstwait_data_after", dout, 32'h0);
        end
        @(posedge clk);
        #1;
        xfer(1, 0, 32'h20, 32'h0, 4'hF, rdata, rerr, blen);
        check("rstwait_readback", rdata, 32'h0F0F0F0F);

        // Initiator drops the write in WAIT; the captured access still completes.
        mem_write = 1'b1;
        adr       = 32'h24;
        wdat      = 32'h77777777;
        sel       = 4'hF;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        blen      = 0;
        for (int n = 0; n < 40 && busy; n++) begin
            @(negedge clk);
            if (busy) blen++;
        end
        check("drop_wait_len", blen, 32'd2);
        check("drop_err", {31'h0, merr}, 32'h0);
        @(posedge clk);
        #1;
        xfer(1, 0, 32'h24, 32'h0, 4'hF, rdata, rerr, blen);
        check("drop_readback", rdata, 32'h77777777);

        for (int k = 0; k < 3; k++) begin
            int lat;
            lat = (k == 0) ? 1 : (k == 1) ? 2 : 15;
            cur = 2'(k);
            do_reset();
            model_mem.delete();
            for (int w = 0; w < 16; w++) begin
                logic [31:0] d = $urandom;
                model_op(0, 1, 32'(w * 4), d, 4'hF, ed, ee);
                xfer(0, 1, 32'(w * 4), d, 4'hF, rdata, rerr, blen);
                check($sformatf("L%0d_pre%0d_err", lat, w), {31'h0, rerr}, {31'h0, ee});
            end
            for (int i = 0; i < 50; i++) begin
                int          op  = $urandom_range(0, 8);
                logic        rd  = (op <= 3) || (op == 8);
                logic        wr  = (op >= 4);
                logic        oor = ($urandom_range(0, 7) == 0);
                logic [19:0] hi  = oor ? (20'($urandom) | 20'h1) : 20'h0;
                logic [31:0] a   = {hi, 6'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
                logic [31:0] d   = $urandom;
                logic [3:0]  s   = 4'($urandom);
                model_op(rd, wr, a, d, s, ed, ee);
                xfer(rd, wr, a, d, s, rdata, rerr, blen);
                check($sformatf("L%0d_rnd%0d_data", lat, i), rdata, ed);
                check($sformatf("L%0d_rnd%0d_err", lat, i), {31'h0, rerr}, {31'h0, ee});
                check($sformatf("L%0d_rnd%0d_busy_len", lat, i), blen, 32'(lat + 1));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
